// File: rtl/elevator_datapath.sv
// elevator_datapath: call latches, floor register and travel/door timers serving the elevator control FSM.
// Optional build macro ELEV_DP_BTN_SYNC_EN adds a 2-flop synchronizer and rising-edge detect per button bit.
module elevator_datapath #(
  parameter int N_FLOORS      = 8,
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_FLOORS-1:0]         btn_cab,
  input  logic [N_FLOORS-1:0]         btn_hall_up,
  input  logic [N_FLOORS-1:0]         btn_hall_dn,
  input  logic [1:0]                  dir,
  input  logic                        delay_3s,
  input  logic                        delay_5s,
  input  logic                        clear_up,
  input  logic                        clear_down,
  input  logic                        clear_all_up,
  input  logic                        clear_all_down,
  input  logic                        clear_stop,
  input  logic                        clear_door,
  output logic                        req_current,
  output logic                        req_up_in,
  output logic                        req_down_in,
  output logic                        req_up_out,
  output logic                        req_down_out,
  output logic                        req_up_max,
  output logic                        req_down_min,
  output logic                        delay_3s_done,
  output logic                        delay_5s_done,
  output logic [$clog2(N_FLOORS)-1:0] floor,
  output logic                        door_open
);
  localparam int FW = $clog2(N_FLOORS);
  localparam int T3 = 3 * TICKS_PER_SEC;
  localparam int T5 = 5 * TICKS_PER_SEC;
  localparam int CW = $clog2(T5);
  localparam logic [CW-1:0]       T3_LAST = CW'(T3 - 1);
  localparam logic [CW-1:0]       T5_LAST = CW'(T5 - 1);
  localparam logic [FW-1:0]       TOP     = FW'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] UP_OK   = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_OK   = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0]   cab, hup, hdn, any_call;
  logic [N_FLOORS-1:0]   above, below, at;
  logic [3*N_FLOORS-1:0] btn_all, set_all;
  logic                  clr_cab, clr_hup, clr_hdn;
  logic [CW-1:0]         cnt3, cnt5;

  assign btn_all = {btn_hall_dn, btn_hall_up, btn_cab};

`ifdef ELEV_DP_BTN_SYNC_EN
  logic [3*N_FLOORS-1:0] sync1, sync2, sync3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= btn_all;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // one set pulse per press, so a held button cannot re-arm a cleared call
  assign set_all = sync2 & ~sync3;
`else
  assign set_all = btn_all;
`endif

  always_comb begin
    above = '0;
    below = '0;
    at    = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      above[i] = FW'(i) > floor;
      below[i] = FW'(i) < floor;
      at[i]    = FW'(i) == floor;
    end
  end

  assign clr_cab = clear_up | clear_down | clear_all_up | clear_all_down | clear_stop;
  assign clr_hup = clear_up | clear_all_up | clear_all_down | clear_stop;
  assign clr_hdn = clear_down | clear_all_up | clear_all_down | clear_stop;

  assign any_call     = cab | hup | hdn;
  assign req_current  = |(any_call & at);
  assign req_up_in    = |(cab & above);
  assign req_down_in  = |(cab & below);
  assign req_up_out   = |((hup | hdn) & above);
  assign req_down_out = |((hup | hdn) & below);
  assign req_up_max   = (floor == TOP) | ~|(any_call & above);
  assign req_down_min = (floor == '0) | ~|(any_call & below);

  assign delay_3s_done = delay_3s & (cnt3 == T3_LAST);
  assign delay_5s_done = delay_5s & ~clear_door & (cnt5 == T5_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cab       <= '0;
      hup       <= '0;
      hdn       <= '0;
      cnt3      <= '0;
      cnt5      <= '0;
      floor     <= '0;
      door_open <= 1'b0;
    end else begin
      // clear masking applied after the set so a same-cycle press is absorbed
      cab <= (cab | set_all[N_FLOORS-1:0]) & ~(at & {N_FLOORS{clr_cab}});
      hup <= (hup | (set_all[2*N_FLOORS-1:N_FLOORS] & UP_OK)) & ~(at & {N_FLOORS{clr_hup}});
      hdn <= (hdn | (set_all[3*N_FLOORS-1:2*N_FLOORS] & DN_OK)) & ~(at & {N_FLOORS{clr_hdn}});

      if (!delay_3s || cnt3 == T3_LAST) cnt3 <= '0;
      else                              cnt3 <= cnt3 + 1'b1;

      if (!delay_5s || clear_door || cnt5 == T5_LAST) cnt5 <= '0;
      else                                            cnt5 <= cnt5 + 1'b1;

      if (delay_3s_done) begin
        case (dir)
          2'b01:   if (floor != TOP) floor <= floor + 1'b1;
          2'b10:   if (floor != '0)  floor <= floor - 1'b1;
          default: floor <= floor;
        endcase
      end

      door_open <= delay_5s;
    end
  end
endmodule

// File: tb/tb_elevator_datapath.sv
// Bench for elevator_datapath: hand-computed vector table, directed timer/floor sequences and a
// randomized run checked every cycle against an array-based behavioural model.
`timescale 1ns/1ps
module tb_elevator_datapath;
  localparam int N      = 8;
  localparam int TPS    = 4;
  localparam int TRAVEL = 3 * TPS;
  localparam int DOOR   = 5 * TPS;
`ifdef ELEV_DP_BTN_SYNC_EN
  localparam int LAT       = 3;
  localparam bit HELD_KEEP = 1'b0;
`else
  localparam int LAT       = 1;
  localparam bit HELD_KEEP = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] btn_cab, btn_hall_up, btn_hall_dn;
  logic [1:0] dir;
  logic delay_3s, delay_5s, clear_up, clear_down, clear_all_up, clear_all_down, clear_stop, clear_door;
  logic req_current, req_up_in, req_down_in, req_up_out, req_down_out, req_up_max, req_down_min;
  logic delay_3s_done, delay_5s_done, door_open;
  logic [2:0] floor;

  int vectors = 0;
  int errors  = 0;
  logic seen3, seen5;

  elevator_datapath #(.N_FLOORS(N), .TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .btn_cab(btn_cab), .btn_hall_up(btn_hall_up), .btn_hall_dn(btn_hall_dn),
    .dir(dir), .delay_3s(delay_3s), .delay_5s(delay_5s), .clear_up(clear_up), .clear_down(clear_down),
    .clear_all_up(clear_all_up), .clear_all_down(clear_all_down), .clear_stop(clear_stop),
    .clear_door(clear_door), .req_current(req_current), .req_up_in(req_up_in), .req_down_in(req_down_in),
    .req_up_out(req_up_out), .req_down_out(req_down_out), .req_up_max(req_up_max),
    .req_down_min(req_down_min), .delay_3s_done(delay_3s_done), .delay_5s_done(delay_5s_done),
    .floor(floor), .door_open(door_open));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  bit m_cab[N], m_hup[N], m_hdn[N];
  logic [3*N-1:0] hist[3];
  int m_floor, m_el3, m_el5;
  bit m_door;

  task automatic model_reset();
    for (int f = 0; f < N; f++) begin m_cab[f] = 0; m_hup[f] = 0; m_hdn[f] = 0; end
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_floor = 0; m_el3 = 0; m_el5 = 0; m_door = 0;
  endtask

  function automatic logic [12:0] model_out();
    bit ui, di, uo, dno, up_any, dn_any, cur, d3, d5;
    ui = 0; di = 0; uo = 0; dno = 0; up_any = 0; dn_any = 0;
    cur = m_cab[m_floor] | m_hup[m_floor] | m_hdn[m_floor];
    for (int f = 0; f < N; f++) begin
      if (f > m_floor) begin
        ui |= m_cab[f]; uo |= m_hup[f] | m_hdn[f]; up_any |= m_cab[f] | m_hup[f] | m_hdn[f];
      end
      if (f < m_floor) begin
        di |= m_cab[f]; dno |= m_hup[f] | m_hdn[f]; dn_any |= m_cab[f] | m_hup[f] | m_hdn[f];
      end
    end
    d3 = delay_3s && m_el3 == TRAVEL - 1;
    d5 = delay_5s && !clear_door && m_el5 == DOOR - 1;
    return {cur, ui, di, uo, dno, !up_any, !dn_any, d3, d5, m_door, 3'(m_floor)};
  endfunction

  task automatic model_edge();
    logic [3*N-1:0] now, set;
    bit cc, cu, cd, d3;
    now = {btn_hall_dn, btn_hall_up, btn_cab};
`ifdef ELEV_DP_BTN_SYNC_EN
    set = hist[1] & ~hist[2];
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = now;
`else
    set = now;
`endif
    cc = clear_up | clear_down | clear_all_up | clear_all_down | clear_stop;
    cu = clear_up | clear_all_up | clear_all_down | clear_stop;
    cd = clear_down | clear_all_up | clear_all_down | clear_stop;
    for (int f = 0; f < N; f++) begin
      m_cab[f] = (f == m_floor && cc) ? 1'b0 : (m_cab[f] | set[f]);
      m_hup[f] = (f == m_floor && cu) ? 1'b0 : (m_hup[f] | (f != N - 1 && set[N + f]));
      m_hdn[f] = (f == m_floor && cd) ? 1'b0 : (m_hdn[f] | (f != 0 && set[2*N + f]));
    end
    d3 = delay_3s && m_el3 == TRAVEL - 1;
    m_el3 = delay_3s ? (m_el3 + 1) % TRAVEL : 0;
    m_el5 = (delay_5s && !clear_door) ? (m_el5 + 1) % DOOR : 0;
    if (d3 && dir == 2'b01 && m_floor < N - 1) m_floor++;
    else if (d3 && dir == 2'b10 && m_floor > 0) m_floor--;
    m_door = delay_5s;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [12:0] got, exp;
    @(negedge clk);
    got = {req_current, req_up_in, req_down_in, req_up_out, req_down_out, req_up_max, req_down_min,
           delay_3s_done, delay_5s_done, door_open, floor};
    exp = model_out();
    seen3 = delay_3s_done;
    seen5 = delay_5s_done;
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
    @(posedge clk);
    if (reset) model_edge();
    else       model_reset();
    #1;
  endtask

  task automatic set_idle();
    btn_cab = '0; btn_hall_up = '0; btn_hall_dn = '0;
    {clear_up, clear_down, clear_all_up, clear_all_down, clear_stop, clear_door} = '0;
  endtask

  task automatic move_to(input int target, input string tag);
    dir = (target > floor) ? 2'b01 : 2'b10;
    delay_3s = 1'b1;
    for (int c = 0; c < 200 && floor != target; c++) tick(tag);
    delay_3s = 1'b0;
    dir = 2'b00;
    check(tag, floor, target);
  endtask

  typedef struct packed {
    logic [N-1:0] cab, hup, hdn;
    logic [5:0]   clr;   // {up, down, all_up, all_down, stop, door}
    logic [6:0]   exp;   // {current, up_in, down_in, up_out, down_out, up_max, down_min}
  } vec_t;

  vec_t tbl[17];
  int pulses, last, first;

  initial begin
    tbl = '{
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0000011},
      '{8'h20, 8'h00, 8'h00, 6'b000000, 7'b0000011},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0100001},
      '{8'h00, 8'h01, 8'h01, 6'b000000, 7'b0100001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b1100001},
      '{8'h00, 8'h00, 8'h00, 6'b100000, 7'b1100001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0100001},
      '{8'h00, 8'h80, 8'h00, 6'b000000, 7'b0100001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0100001},
      '{8'h00, 8'h00, 8'h08, 6'b000000, 7'b0100001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0101001},
      '{8'h01, 8'h00, 8'h00, 6'b000010, 7'b0101001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0101001},
      '{8'h01, 8'h00, 8'h00, 6'b000000, 7'b0101001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b1101001},
      '{8'h00, 8'h00, 8'h00, 6'b010000, 7'b1101001},
      '{8'h00, 8'h00, 8'h00, 6'b000000, 7'b0101001}};

    set_idle();
    dir = 2'b00; delay_3s = 1'b0; delay_5s = 1'b0;
    model_reset();
    repeat (3) tick("in_reset");
    reset = 1'b1;
    check("reset_req", {req_current, req_up_in, req_down_in, req_up_out, req_down_out,
                        req_up_max, req_down_min}, 7'b0000011);
    check("reset_floor", floor, 0);

`ifndef ELEV_DP_BTN_SYNC_EN
    for (int i = 0; i < $size(tbl); i++) begin
      btn_cab = tbl[i].cab; btn_hall_up = tbl[i].hup; btn_hall_dn = tbl[i].hdn;
      {clear_up, clear_down, clear_all_up, clear_all_down, clear_stop, clear_door} = tbl[i].clr;
      #2;
      check($sformatf("table[%0d]", i), {req_current, req_up_in, req_down_in, req_up_out,
                                         req_down_out, req_up_max, req_down_min}, tbl[i].exp);
      tick("table");
    end
    set_idle();
`endif

    // travel from 0 to 5 on a cabin call
    btn_cab[5] = 1'b1; tick("press5"); btn_cab = '0;
    repeat (3) tick("press5");
    check("cab5_up_in", req_up_in, 1);
    check("cab5_up_max", req_up_max, 0);
    dir = 2'b01; delay_3s = 1'b1; pulses = 0; last = 0;
    for (int c = 1; c <= 100 && floor != 5; c++) begin
      tick("travel");
      if (seen3) begin check("travel_gap", c - last, TRAVEL); last = c; pulses++; end
    end
    delay_3s = 1'b0; dir = 2'b00;
    check("travel_floor", floor, 5);
    check("travel_pulses", pulses, 5);
    check("at5_current", req_current, 1);
    check("at5_up_max", req_up_max, 1);
    clear_up = 1'b1; tick("clear_up"); clear_up = 1'b0;
    check("cleared5_current", req_current, 0);

    // saturation at the top floor
    move_to(7, "to_top");
    dir = 2'b01; delay_3s = 1'b1; pulses = 0;
    repeat (TRAVEL) begin tick("saturate"); if (seen3) pulses++; end
    delay_3s = 1'b0; dir = 2'b00;
    check("saturate_pulses", pulses, 1);
    check("saturate_floor", floor, 7);

    // door timer restarted by clear_door
    delay_5s = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      clear_door = (c == 15);
      tick("door");
      check($sformatf("door_done_c%0d", c), seen5, c == 35);
      if (c >= 1) check($sformatf("door_open_c%0d", c), door_open, 1);
    end
    delay_5s = 1'b0; clear_door = 1'b0;

    // press absorbed by a same-cycle clear at floor 3, then a hall-down below
    move_to(3, "to_3");
    for (int c = 0; c < LAT; c++) begin
      btn_hall_up[3] = (c == 0);
      clear_stop = (c == LAT - 1);
      tick("absorb");
    end
    set_idle();
    repeat (3) tick("absorb");
    check("absorb_current", req_current, 0);
    btn_hall_dn[2] = 1'b1; tick("hall_dn2"); btn_hall_dn = '0;
    repeat (LAT) tick("hall_dn2");
    check("hall_dn2_down_out", req_down_out, 1);

    // reset partway through a travel interval
    dir = 2'b01; delay_3s = 1'b1;
    repeat (8) tick("pre_reset");
    #3 reset = 1'b0; model_reset();
    #1;
    check("midreset_floor", floor, 0);
    check("midreset_done", delay_3s_done, 0);
    repeat (2) tick("midreset");
    reset = 1'b1;
    first = 0;
    for (int c = 1; c <= 30 && first == 0; c++) begin tick("post_reset"); if (seen3) first = c; end
    check("post_reset_first_pulse", first, TRAVEL);
    delay_3s = 1'b0; dir = 2'b00;

    // held cabin button at floor 4
    move_to(4, "to_4");
    btn_cab[4] = 1'b1;
    first = 0;
    for (int c = 1; c <= 8; c++) begin tick("held4"); if (first == 0 && req_current) first = c; end
    check("held4_latency", first, LAT);
    clear_stop = 1'b1; tick("held4_clear"); clear_stop = 1'b0;
    repeat (4) tick("held4_after");
    check("held4_rearm", req_current, HELD_KEEP);
    btn_cab = '0;
    clear_stop = 1'b1; tick("held4_clear"); clear_stop = 1'b0;

    // randomized run against the model
    for (int i = 0; i < 600; i++) begin
      btn_cab     = N'($urandom & $urandom & $urandom & $urandom);
      btn_hall_up = N'($urandom & $urandom & $urandom & $urandom);
      btn_hall_dn = N'($urandom & $urandom & $urandom & $urandom);
      dir = 2'($urandom_range(0, 3));
      delay_3s = ($urandom_range(0, 7) != 0);
      delay_5s = ($urandom_range(0, 3) != 0);
      clear_up = ($urandom_range(0, 15) == 0);
      clear_down = ($urandom_range(0, 15) == 0);
      clear_all_up = ($urandom_range(0, 15) == 0);
      clear_all_down = ($urandom_range(0, 15) == 0);
      clear_stop = ($urandom_range(0, 15) == 0);
      clear_door = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #3 reset = 1'b0; model_reset();
        tick("random_reset");
        reset = 1'b1;
      end else begin
        tick("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
